// File: rtl/sdspi_word_loader.sv
// sdspi_word_loader: packs the SD file-reader byte stream into WORD_BYTES-wide words
// and writes them to consecutive addresses from BASE_ADDR through a small word FIFO.
module sdspi_word_loader #(
    parameter int                WORD_BYTES = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       LOAD_BYTES = 65536,
    parameter int                FIFO_DEPTH = 4,
    parameter bit                BIG_ENDIAN = 1'b0,
    localparam int               DW         = 8 * WORD_BYTES
) (
    input  logic              clk27mhz,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DW-1:0]     mem_data,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [31:0]       byte_count,
    output logic [31:0]       checksum
);

    localparam int          LANE_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int          PTR_W      = $clog2(FIFO_DEPTH);
    localparam int          CNT_W      = PTR_W + 1;
    localparam logic [31:0] LOAD_LIMIT = 32'(LOAD_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t            state;
    logic [LANE_W-1:0] lane;
    logic [DW-1:0]     pack_reg;
    logic [DW-1:0]     pack_next;
    logic [ADDR_W-1:0] wr_addr;

    logic [DW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  fifo_wr_ptr;
    logic [PTR_W-1:0]  fifo_rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic start_ok;
    logic accept;
    logic word_done;
    logic flush_push;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic push_ok;
    logic [DW-1:0] push_word;

    assign start_ok   = start && (state == S_IDLE || state == S_DONE);
    assign accept     = (state == S_LOAD) && in_valid && (byte_count < LOAD_LIMIT);
    assign word_done  = accept && (lane == LANE_W'(WORD_BYTES - 1));
    // A partially filled packer is pushed on the first FLUSH cycle; unused lanes are already zero.
    assign flush_push = (state == S_FLUSH) && (lane != '0);
    assign push       = word_done || flush_push;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && mem_ready;
    assign push_ok    = push && (!fifo_full || pop);
    assign push_word  = flush_push ? pack_reg : pack_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pack_next = pack_reg;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (lane == LANE_W'(i)) begin
                pack_next[(BIG_ENDIAN ? (WORD_BYTES - 1 - i) : i) * 8 +: 8] = in_byte;
            end
        end
    end

    // Outputs are forced to zero while the FIFO is empty so that reset shows all-zero outputs.
    assign mem_valid = !fifo_empty;
    assign mem_addr  = mem_valid ? wr_addr : '0;
    assign mem_data  = mem_valid ? fifo_mem[fifo_rd_ptr] : '0;

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk27mhz or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
            checksum   <= '0;
            lane       <= '0;
            pack_reg   <= '0;
            wr_addr    <= BASE_ADDR;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        overflow   <= 1'b0;
                        byte_count <= '0;
                        checksum   <= '0;
                        lane       <= '0;
                        pack_reg   <= '0;
                        wr_addr    <= BASE_ADDR;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        byte_count <= byte_count + 32'd1;
                        checksum   <= checksum + {24'h0, in_byte};
                        if (word_done) begin
                            lane     <= '0;
                            pack_reg <= '0;
                        end else begin
                            lane     <= lane + LANE_W'(1);
                            pack_reg <= pack_next;
                        end
                        if (in_last || (byte_count + 32'd1 == LOAD_LIMIT)) begin
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (lane != '0) begin
                        lane     <= '0;
                        pack_reg <= '0;
                    end else if (fifo_empty) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            endcase

            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                wr_addr <= wr_addr + ADDR_W'(WORD_BYTES);
            end
        end
    end

    always_ff @(posedge clk27mhz or posedge reset) begin
        if (reset) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
        end else if (start_ok) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (push_ok) begin
                fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk27mhz) begin
        if (push_ok) begin
            fifo_mem[fifo_wr_ptr] <= push_word;
        end
    end

endmodule

// File: tb/tb_sdspi_word_loader.sv
// Directed bench for sdspi_word_loader: five instances cover LE/BE packing, the load limit,
// FIFO overflow under stall, mid-load reset, and 1- and 8-byte words.
module tb_sdspi_word_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk27mhz  = 1'b0;
    logic        reset     = 1'b1;
    logic [4:0]  start     = '0;
    logic        in_valid  = 1'b0;
    logic [7:0]  in_byte   = '0;
    logic        in_last   = 1'b0;
    logic        mem_ready = 1'b1;

    logic        mem_valid  [5];
    logic [31:0] mem_addr   [5];
    logic        busy       [5];
    logic        done       [5];
    logic        overflow   [5];
    logic [31:0] byte_count [5];
    logic [31:0] checksum   [5];
    logic [31:0] mem_data_le, mem_data_be, mem_data_lb8;
    logic [7:0]  mem_data_w1;
    logic [63:0] mem_data_w8;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;
    wr_t wq[$];

    always #5 clk27mhz = ~clk27mhz;

    sdspi_word_loader #(.WORD_BYTES(4), .BASE_ADDR(BASE)) u_le (
        .clk27mhz(clk27mhz), .reset(reset), .start(start[0]), .in_valid(in_valid),
        .in_byte(in_byte), .in_last(in_last), .mem_valid(mem_valid[0]), .mem_addr(mem_addr[0]),
        .mem_data(mem_data_le), .mem_ready(mem_ready), .busy(busy[0]), .done(done[0]),
        .overflow(overflow[0]), .byte_count(byte_count[0]), .checksum(checksum[0]));

    sdspi_word_loader #(.WORD_BYTES(4), .BASE_ADDR(BASE), .BIG_ENDIAN(1'b1)) u_be (
        .clk27mhz(clk27mhz), .reset(reset), .start(start[1]), .in_valid(in_valid),
        .in_byte(in_byte), .in_last(in_last), .mem_valid(mem_valid[1]), .mem_addr(mem_addr[1]),
        .mem_data(mem_data_be), .mem_ready(mem_ready), .busy(busy[1]), .done(done[1]),
        .overflow(overflow[1]), .byte_count(byte_count[1]), .checksum(checksum[1]));

    sdspi_word_loader #(.WORD_BYTES(4), .BASE_ADDR(BASE), .LOAD_BYTES(8)) u_lb8 (
        .clk27mhz(clk27mhz), .reset(reset), .start(start[2]), .in_valid(in_valid),
        .in_byte(in_byte), .in_last(in_last), .mem_valid(mem_valid[2]), .mem_addr(mem_addr[2]),
        .mem_data(mem_data_lb8), .mem_ready(mem_ready), .busy(busy[2]), .done(done[2]),
        .overflow(overflow[2]), .byte_count(byte_count[2]), .checksum(checksum[2]));

    sdspi_word_loader #(.WORD_BYTES(1), .BASE_ADDR(BASE)) u_w1 (
        .clk27mhz(clk27mhz), .reset(reset), .start(start[3]), .in_valid(in_valid),
        .in_byte(in_byte), .in_last(in_last), .mem_valid(mem_valid[3]), .mem_addr(mem_addr[3]),
        .mem_data(mem_data_w1), .mem_ready(mem_ready), .busy(busy[3]), .done(done[3]),
        .overflow(overflow[3]), .byte_count(byte_count[3]), .checksum(checksum[3]));

    sdspi_word_loader #(.WORD_BYTES(8), .BASE_ADDR(BASE)) u_w8 (
        .clk27mhz(clk27mhz), .reset(reset), .start(start[4]), .in_valid(in_valid),
        .in_byte(in_byte), .in_last(in_last), .mem_valid(mem_valid[4]), .mem_addr(mem_addr[4]),
        .mem_data(mem_data_w8), .mem_ready(mem_ready), .busy(busy[4]), .done(done[4]),
        .overflow(overflow[4]), .byte_count(byte_count[4]), .checksum(checksum[4]));

    // Inputs change just after posedge, so a negedge sample predicts the next edge's handshake.
    always @(negedge clk27mhz) begin
        if (!reset && mem_ready) begin
            if (mem_valid[0]) wq.push_back({3'd0, mem_addr[0], {32'h0, mem_data_le}});
            if (mem_valid[1]) wq.push_back({3'd1, mem_addr[1], {32'h0, mem_data_be}});
            if (mem_valid[2]) wq.push_back({3'd2, mem_addr[2], {32'h0, mem_data_lb8}});
            if (mem_valid[3]) wq.push_back({3'd3, mem_addr[3], {56'h0, mem_data_w1}});
            if (mem_valid[4]) wq.push_back({3'd4, mem_addr[4], mem_data_w8});
        end
    end

    task automatic tick();
        @(posedge clk27mhz);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start(input int id);
        start[id] = 1'b1;
        tick();
        start[id] = 1'b0;
    endtask

    task automatic wait_done(input int id, input string name);
        int n = 0;
        while (done[id] !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (done[id] !== 1'b1 || busy[id] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done/busy: got %b/%b want 1/0", name, done[id], busy[id]);
        end
    endtask

    task automatic test_reset();
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({mem_valid[i], busy[i], done[i], overflow[i]} !== 4'b0 ||
                byte_count[i] !== 32'h0 || checksum[i] !== 32'h0 || mem_addr[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: valid=%b busy=%b done=%b ovf=%b cnt=%h sum=%h addr=%h want all 0",
                         i, mem_valid[i], busy[i], done[i], overflow[i], byte_count[i], checksum[i], mem_addr[i]);
            end
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        send(8'h99, 1'b0);
        n_checks++;
        if (byte_count[0] !== 32'h0 || checksum[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_drop: cnt=%h sum=%h want 0/0", byte_count[0], checksum[0]);
        end
    endtask

    task automatic test_le_basic();
        logic [31:0] ea [2] = '{BASE, BASE + 32'd4};
        logic [63:0] ed [2] = '{64'h0403_0201, 64'h0807_0605};
        wq.delete();
        pulse_start(0);
        for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
        wait_done(0, "le_basic");
        n_checks++;
        if (wq.size() != 2) begin
            n_fail++;
            $display("FAIL le_basic write_count: got %0d want 2", wq.size());
        end
        for (int i = 0; i < 2 && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i].id != 3'd0 || wq[i].addr !== ea[i] || wq[i].data !== ed[i]) begin
                n_fail++;
                $display("FAIL le_basic write%0d: got dut%0d %h:%h want dut0 %h:%h",
                         i, wq[i].id, wq[i].addr, wq[i].data, ea[i], ed[i]);
            end
        end
        n_checks++;
        if (byte_count[0] !== 32'd8 || checksum[0] !== 32'h24 || overflow[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL le_basic stats: cnt=%0d sum=%h ovf=%b want 8/24/0", byte_count[0], checksum[0], overflow[0]);
        end
    endtask

    task automatic test_big_endian();
        logic [7:0]  bytes [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        logic [31:0] ea [2] = '{BASE, BASE + 32'd4};
        logic [63:0] ed [2] = '{64'hAABB_CCDD, 64'hEEFF_0000};
        wq.delete();
        pulse_start(1);
        for (int i = 0; i < 6; i++) send(bytes[i], i == 5);
        wait_done(1, "big_endian");
        n_checks++;
        if (wq.size() != 2) begin
            n_fail++;
            $display("FAIL big_endian write_count: got %0d want 2", wq.size());
        end
        for (int i = 0; i < 2 && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i].id != 3'd1 || wq[i].addr !== ea[i] || wq[i].data !== ed[i]) begin
                n_fail++;
                $display("FAIL big_endian write%0d: got dut%0d %h:%h want dut1 %h:%h",
                         i, wq[i].id, wq[i].addr, wq[i].data, ea[i], ed[i]);
            end
        end
        n_checks++;
        if (byte_count[1] !== 32'd6 || checksum[1] !== 32'h4FB) begin
            n_fail++;
            $display("FAIL big_endian stats: cnt=%0d sum=%h want 6/4fb", byte_count[1], checksum[1]);
        end
        n_checks++;
        if (byte_count[0] !== 32'd8 || done[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL done_drop: cnt=%0d done=%b want 8/1", byte_count[0], done[0]);
        end
    endtask

    task automatic test_load_limit();
        logic [31:0] ea [2] = '{BASE, BASE + 32'd4};
        logic [63:0] ed [2] = '{64'h1312_1110, 64'h1716_1514};
        wq.delete();
        pulse_start(2);
        for (int i = 0; i < 12; i++) send(8'h10 + 8'(i), 1'b0);
        wait_done(2, "load_limit");
        n_checks++;
        if (wq.size() != 2) begin
            n_fail++;
            $display("FAIL load_limit write_count: got %0d want 2", wq.size());
        end
        for (int i = 0; i < 2 && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i].id != 3'd2 || wq[i].addr !== ea[i] || wq[i].data !== ed[i]) begin
                n_fail++;
                $display("FAIL load_limit write%0d: got dut%0d %h:%h want dut2 %h:%h",
                         i, wq[i].id, wq[i].addr, wq[i].data, ea[i], ed[i]);
            end
        end
        n_checks++;
        if (byte_count[2] !== 32'd8 || checksum[2] !== 32'h9C) begin
            n_fail++;
            $display("FAIL load_limit stats: cnt=%0d sum=%h want 8/9c", byte_count[2], checksum[2]);
        end
    endtask

    task automatic test_stall_overflow();
        logic [31:0] ea [5] = '{BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'd12, BASE + 32'd16};
        logic [63:0] ed [5] = '{64'h0403_0201, 64'h0807_0605, 64'h0C0B_0A09, 64'h100F_0E0D, 64'h0000_0055};
        logic [31:0] a0, d0;
        int moved = 0;
        wq.delete();
        mem_ready = 1'b0;
        pulse_start(0);
        for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
        n_checks++;
        if (overflow[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall overflow_early: got %b want 0", overflow[0]);
        end
        for (int i = 17; i <= 20; i++) send(8'(i), 1'b0);
        n_checks++;
        if (overflow[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall overflow_5th: got %b want 1", overflow[0]);
        end
        a0 = mem_addr[0];
        d0 = mem_data_le;
        n_checks++;
        if (mem_valid[0] !== 1'b1 || a0 !== BASE || d0 !== 32'h0403_0201) begin
            n_fail++;
            $display("FAIL stall head: got %b %h:%h want 1 %h:04030201", mem_valid[0], a0, d0, BASE);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_valid[0] !== 1'b1 || mem_addr[0] !== a0 || mem_data_le !== d0) moved++;
        end
        n_checks++;
        if (moved != 0 || wq.size() != 0) begin
            n_fail++;
            $display("FAIL stall stable: changes=%0d writes=%0d want 0/0", moved, wq.size());
        end
        mem_ready = 1'b1;
        send(8'h55, 1'b1);
        wait_done(0, "stall");
        n_checks++;
        if (wq.size() != 5) begin
            n_fail++;
            $display("FAIL stall write_count: got %0d want 5", wq.size());
        end
        for (int i = 0; i < 5 && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i].id != 3'd0 || wq[i].addr !== ea[i] || wq[i].data !== ed[i]) begin
                n_fail++;
                $display("FAIL stall write%0d: got dut%0d %h:%h want dut0 %h:%h",
                         i, wq[i].id, wq[i].addr, wq[i].data, ea[i], ed[i]);
            end
        end
        n_checks++;
        if (byte_count[0] !== 32'd21 || checksum[0] !== 32'h127 || overflow[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall stats: cnt=%0d sum=%h ovf=%b want 21/127/1", byte_count[0], checksum[0], overflow[0]);
        end
    endtask

    task automatic test_reset_midload();
        wq.delete();
        pulse_start(0);
        for (int i = 1; i <= 14; i++) send(8'(i), 1'b0);
        n_checks++;
        if (wq.size() != 3 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midload pre_reset: writes=%0d busy=%b want 3/1", wq.size(), busy[0]);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_valid[0], busy[0], done[0], overflow[0]} !== 4'b0 || byte_count[0] !== 32'h0 ||
            checksum[0] !== 32'h0 || mem_addr[0] !== 32'h0 || mem_data_le !== 32'h0) begin
            n_fail++;
            $display("FAIL midload reset_outputs: valid=%b busy=%b done=%b ovf=%b cnt=%h sum=%h addr=%h data=%h want all 0",
                     mem_valid[0], busy[0], done[0], overflow[0], byte_count[0], checksum[0], mem_addr[0], mem_data_le);
        end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        wq.delete();
        pulse_start(0);
        for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i), i == 3);
        wait_done(0, "midload_restart");
        n_checks++;
        if (wq.size() != 1 || wq[0].id != 3'd0 || wq[0].addr !== BASE || wq[0].data !== 64'hA4A3_A2A1) begin
            n_fail++;
            $display("FAIL midload restart_write: got n=%0d first=%h want n=1 dut0 %h:a4a3a2a1",
                     wq.size(), (wq.size() > 0) ? wq[0] : wr_t'(0), BASE);
        end
    endtask

    task automatic test_word_widths();
        logic [63:0] ed8 [2] = '{64'h8786_8584_8382_8180, 64'h0000_0000_8B8A_8988};
        wq.delete();
        pulse_start(3);
        for (int i = 0; i < 3; i++) send(8'h31 + 8'(i), i == 2);
        wait_done(3, "width1");
        n_checks++;
        if (wq.size() != 3) begin
            n_fail++;
            $display("FAIL width1 write_count: got %0d want 3", wq.size());
        end
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i].id != 3'd3 || wq[i].addr !== BASE + 32'(i) || wq[i].data !== 64'(8'h31 + 8'(i))) begin
                n_fail++;
                $display("FAIL width1 write%0d: got dut%0d %h:%h want dut3 %h:%h",
                         i, wq[i].id, wq[i].addr, wq[i].data, BASE + 32'(i), 8'h31 + 8'(i));
            end
        end
        wq.delete();
        pulse_start(4);
        for (int i = 0; i < 12; i++) send(8'h80 + 8'(i), i == 11);
        wait_done(4, "width8");
        n_checks++;
        if (wq.size() != 2) begin
            n_fail++;
            $display("FAIL width8 write_count: got %0d want 2", wq.size());
        end
        for (int i = 0; i < 2 && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i].id != 3'd4 || wq[i].addr !== BASE + 32'(8 * i) || wq[i].data !== ed8[i]) begin
                n_fail++;
                $display("FAIL width8 write%0d: got dut%0d %h:%h want dut4 %h:%h",
                         i, wq[i].id, wq[i].addr, wq[i].data, BASE + 32'(8 * i), ed8[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        wq.delete();
        pulse_start(2);
        for (int i = 0; i < 3; i++) send(8'hC1 + 8'(i), i == 2);
        wait_done(2, "back_to_back");
        n_checks++;
        if (wq.size() != 1 || wq[0].id != 3'd2 || wq[0].addr !== BASE || wq[0].data !== 64'h00C3_C2C1) begin
            n_fail++;
            $display("FAIL back_to_back write: got n=%0d first=%h want n=1 dut2 %h:00c3c2c1",
                     wq.size(), (wq.size() > 0) ? wq[0] : wr_t'(0), BASE);
        end
        n_checks++;
        if (byte_count[2] !== 32'd3 || checksum[2] !== 32'h246 || overflow[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back stats: cnt=%0d sum=%h ovf=%b want 3/246/0", byte_count[2], checksum[2], overflow[2]);
        end
    endtask

    initial begin
        test_reset();
        test_le_basic();
        test_big_endian();
        test_load_limit();
        test_stall_overflow();
        test_reset_midload();
        test_word_widths();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
